aes_rx_packer: RTL and testbench

- Sits directly downstream of the verify-platform receive port, aes_rx.
- Consumes the byte stream that port produces and packs each group of 16 bytes into one 128-bit AES block, MSB-first.
- Presents each block to the checker/scoreboard over a valid/ready handshake.
- Discards short or stalled partial blocks and flags them.

---
 rtl/aes_rx_packer.sv | 144 ++++++++++++++
 tb/tb_aes_rx_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_rx_packer.sv
// Packs the aes_rx byte stream into NBYTES-wide AES blocks (first byte in the MSBs)
// and discards short or stalled partial blocks. Define AES_RX_PACKER_CNT_EN for blk_cnt/err_cnt.
module aes_rx_packer #(
  parameter int NBYTES  = 16,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  output logic [8*NBYTES-1:0] out_data,
  input  logic                out_ready,
  output logic                out_err
`ifdef AES_RX_PACKER_CNT_EN
  ,
  output logic [15:0]         blk_cnt,
  output logic [15:0]         err_cnt
`endif
);

  localparam int DATA_W = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     tmo;
  logic [DATA_W-1:0] asm_p0;
  logic [DATA_W-1:0] asm_ins;
  logic              acc;
  logic              xfer;
  logic              done;
  logic              short_frame;

  assign acc         = in_valid && in_ready;
  assign xfer        = out_valid && out_ready;
  assign done        = acc && (cnt == LAST_IDX);
  assign short_frame = acc && in_last && !done;

  // Assembly register with the incoming byte merged at its slot
  always_comb begin
    asm_ins = asm_p0;
    for (int k = 0; k < NBYTES; k++) begin
      if (cnt == CW'(k)) asm_ins[8*(NBYTES-k)-1 -: 8] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) asm_p0 <= asm_ins;
  end

  // Control FSM plus output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tmo       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      out_err <= 1'b0;
      // Drained with nothing new to load; a load below overrides this
      if (xfer) out_valid <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (done) begin
            cnt <= '0;
            tmo <= '0;
            if (!out_valid || out_ready) begin
              out_data  <= asm_ins;
              out_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              state    <= FULL;
              in_ready <= 1'b0;
            end
          end else if (short_frame) begin
            cnt     <= '0;
            tmo     <= '0;
            state   <= IDLE;
            out_err <= 1'b1;
          end else if (acc) begin
            cnt   <= cnt + CW'(1);
            tmo   <= '0;
            state <= FILL;
          end else if (state == FILL) begin
            if (tmo == TMO_LAST) begin
              cnt     <= '0;
              tmo     <= '0;
              state   <= IDLE;
              out_err <= 1'b1;
            end else begin
              tmo <= tmo + TW'(1);
            end
          end
        end
        FULL: begin
          if (xfer) begin
            out_data  <= asm_p0;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          tmo      <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef AES_RX_PACKER_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (xfer)    blk_cnt <= sat_inc(blk_cnt);
      if (out_err) err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_aes_rx_packer.sv
// Directed bench for aes_rx_packer: block packing, backpressure, short frame,
// timeout and mid-block reset, with hand-computed expected blocks.
module tb_aes_rx_packer;

  localparam int NB  = 16;
  localparam int TMO = 8;
  localparam int TWL = 4;

  localparam logic [127:0] BLK00 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK10 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] BLK20 = 128'h202122232425262728292A2B2C2D2E2F;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic         out_err;
`ifdef AES_RX_PACKER_CNT_EN
  logic [15:0]  blk_cnt;
  logic [15:0]  err_cnt;
`endif

  int   total = 0;
  int   bad   = 0;
  logic ir_drop;
  logic err_seen;

  always #5 clk = ~clk;

  aes_rx_packer #(.NBYTES(NB), .TIMEOUT(TMO), .TW(TWL)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .out_err  (out_err)
`ifdef AES_RX_PACKER_CNT_EN
    ,
    .blk_cnt  (blk_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  function automatic logic [127:0] mk(input logic [7:0] base);
    logic [127:0] v = '0;
    logic [7:0]   b = base;
    for (int i = 0; i < 16; i++) begin
      v = {v[119:0], b};
      b = b + 8'd1;
    end
    return v;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    if (!in_ready) ir_drop = 1'b1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run(input logic [7:0] base, input int n, input logic l);
    for (int i = 0; i < n; i++) send(base + 8'(i), l && (i == n - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (out_err) err_seen = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    ir_drop = 1'b0; err_seen = 1'b0;
    step(); step();
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_out_data", out_data, 128'h0);
    chk1("rst_out_err", out_err, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // single block
    run(8'h00, 15, 1'b0);
    chk1("s1_no_early_valid", out_valid, 1'b0);
    send(8'h0F, 1'b1);
    chk1("s1_valid", out_valid, 1'b1);
    chkw("s1_data", out_data, BLK00);
    chk1("s1_err", out_err, 1'b0);
    idle(1);
    chk1("s1_valid_fall", out_valid, 1'b0);
    chkw("s1_data_retained", out_data, BLK00);

    // two contiguous blocks
    ir_drop = 1'b0;
    run(8'h10, 16, 1'b0);
    chk1("s2_valid_a", out_valid, 1'b1);
    chkw("s2_data_a", out_data, BLK10);
    run(8'h20, 16, 1'b1);
    chk1("s2_valid_b", out_valid, 1'b1);
    chkw("s2_data_b", out_data, BLK20);
    chk1("s2_in_ready_held", ir_drop, 1'b0);
    idle(1);

    // backpressure: second block waits in assembly
    out_ready = 1'b0;
    run(8'h30, 16, 1'b0);
    chk1("s3_valid_a", out_valid, 1'b1);
    chkw("s3_data_a", out_data, mk(8'h30));
    run(8'h40, 15, 1'b0);
    chk1("s3_in_ready_fill", in_ready, 1'b1);
    send(8'h4F, 1'b1);
    chk1("s3_in_ready_full", in_ready, 1'b0);
    chkw("s3_data_stable", out_data, mk(8'h30));
    idle(2);
    chkw("s3_data_stable2", out_data, mk(8'h30));
    chk1("s3_in_ready_full2", in_ready, 1'b0);
    out_ready = 1'b1;
    chk1("s3_valid_pre", out_valid, 1'b1);
    chkw("s3_data_pre", out_data, mk(8'h30));
    step();
    chk1("s3_valid_b", out_valid, 1'b1);
    chkw("s3_data_b", out_data, mk(8'h40));
    chk1("s3_in_ready_back", in_ready, 1'b1);
    step();
    chk1("s3_valid_fall", out_valid, 1'b0);

    // short frame then a clean block
    run(8'h50, 4, 1'b0);
    send(8'h54, 1'b1);
    chk1("s4_err", out_err, 1'b1);
    chk1("s4_no_valid", out_valid, 1'b0);
    step();
    chk1("s4_err_one_cycle", out_err, 1'b0);
    run(8'h60, 16, 1'b1);
    chk1("s4_valid", out_valid, 1'b1);
    chkw("s4_data", out_data, mk(8'h60));
    chk1("s4_no_err_on_block", out_err, 1'b0);
    step();

    // short-frame discard coincides with an output transfer
    out_ready = 1'b0;
    run(8'h70, 16, 1'b0);
    chkw("s4b_data", out_data, mk(8'h70));
    run(8'hE0, 2, 1'b0);
    out_ready = 1'b1;
    send(8'hE2, 1'b1);
    chk1("s4b_valid_drained", out_valid, 1'b0);
    chk1("s4b_err", out_err, 1'b1);
    step();

    // timeout after 7 bytes
    run(8'h80, 7, 1'b0);
    err_seen = 1'b0;
    idle(TMO - 1);
    chk1("s5_no_early_err", err_seen, 1'b0);
    step();
    chk1("s5_err", out_err, 1'b1);
    step();
    chk1("s5_err_one_cycle", out_err, 1'b0);
    run(8'h90, 16, 1'b0);
    chk1("s5_valid", out_valid, 1'b1);
    chkw("s5_data", out_data, mk(8'h90));
    step();

    // accepted bytes restart the idle count
    err_seen = 1'b0;
    run(8'hA0, 1, 1'b0);
    idle(TMO - 1);
    run(8'hA1, 1, 1'b0);
    idle(TMO - 1);
    run(8'hA2, 14, 1'b1);
    chk1("s5b_no_err", err_seen, 1'b0);
    chkw("s5b_data", out_data, mk(8'hA0));
    step();

    // reset in the middle of a block
    run(8'hB0, 9, 1'b0);
    rst = 1'b1;
    step();
    chk1("s6_valid", out_valid, 1'b0);
    chk1("s6_err", out_err, 1'b0);
    chk1("s6_in_ready", in_ready, 1'b1);
    chkw("s6_data_clr", out_data, 128'h0);
    rst = 1'b0;
    step();
    chk1("s6_no_err_after", out_err, 1'b0);
    run(8'hC0, 16, 1'b1);
    chk1("s6_valid_blk", out_valid, 1'b1);
    chkw("s6_data_blk", out_data, mk(8'hC0));
    step();

`ifdef AES_RX_PACKER_CNT_EN
    chkw("cnt_blk", 128'(blk_cnt), 128'd1);
    chkw("cnt_err0", 128'(err_cnt), 128'd0);
    run(8'hD0, 2, 1'b1);
    step();
    chkw("cnt_err1", 128'(err_cnt), 128'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
